// File: rtl/seg_pkg.sv
// Shared constants for the scanned 7-segment display: FSM encodings and
// active-low segment patterns ({a,b,c,d,e,f,g,dp}, dp always off).
package seg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_T     = 8'hE1;
    localparam logic [7:0] SEG_DASH  = 8'hFD;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 8'h03;
            4'd1:    seg_digit = 8'h9F;
            4'd2:    seg_digit = 8'h25;
            4'd3:    seg_digit = 8'h0D;
            4'd4:    seg_digit = 8'h99;
            4'd5:    seg_digit = 8'h49;
            4'd6:    seg_digit = 8'h41;
            4'd7:    seg_digit = 8'h1F;
            4'd8:    seg_digit = 8'h01;
            4'd9:    seg_digit = 8'h09;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, DATA_W cycles per word.
// done is high during the final shift; bcd is valid from the next cycle.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [19:0]       bcd
);

    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] shift;
    logic [19:0]       scratch;
    logic [19:0]       adj;
    logic [CW-1:0]     cnt;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    assign done = busy && (cnt == CW'(DATA_W - 1));
    assign bcd  = scratch;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            shift   <= '0;
            scratch <= '0;
        end else if (!busy && start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            shift   <= din;
            scratch <= '0;
        end else if (busy) begin
            scratch <= {adj[18:0], shift[DATA_W-1]};
            shift   <= shift << 1;
            cnt     <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Word -> BCD -> 8-digit multiplexed 7-segment display.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zero value digits.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_2,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [1:0]        modulo,
    input  logic [2:0]        prog,
    output logic [7:0]        an,
    output logic [7:0]        dec_ddp
);

    localparam int SW = $clog2(SCAN_DIV);

    logic [1:0]        state;
    logic              pend_valid;
    logic [DATA_W-1:0] pend_data;
    logic [19:0]       disp;
    logic [SW-1:0]     scan_cnt;
    logic [2:0]        idx;
    logic              start;
    logic              capture;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;
    logic [19:0]       bcd;
    logic [4:1]        lz;
    logic [7:0]        seg_next;

    assign data_ready = (state == ST_IDLE);
    assign start      = data_ready && !busy && (pend_valid || data_valid);
    assign din        = pend_valid ? pend_data : data_2;
    // A word arriving while a pending word is being started is kept, not lost.
    assign capture    = data_valid && (!data_ready || pend_valid);

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            disp       <= '0;
        end else begin
            if (capture) begin
                pend_valid <= 1'b1;
                pend_data  <= data_2;
            end else if (start && pend_valid) begin
                pend_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: if (start) state <= ST_CONV;
                ST_CONV: if (done) state <= ST_LOAD;
                ST_LOAD: begin
                    disp  <= bcd;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign lz[4] = (disp[19:16] == 4'd0);
    assign lz[3] = lz[4] && (disp[15:12] == 4'd0);
    assign lz[2] = lz[3] && (disp[11:8] == 4'd0);
    assign lz[1] = lz[2] && (disp[7:4] == 4'd0);
`else
    assign lz = '0;
`endif

    always_comb begin
        seg_next = SEG_BLANK;
        case (idx)
            3'd0: seg_next = seg_digit(disp[3:0]);
            3'd1: seg_next = lz[1] ? SEG_BLANK : seg_digit(disp[7:4]);
            3'd2: seg_next = lz[2] ? SEG_BLANK : seg_digit(disp[11:8]);
            3'd3: seg_next = lz[3] ? SEG_BLANK : seg_digit(disp[15:12]);
            3'd4: seg_next = lz[4] ? SEG_BLANK : seg_digit(disp[19:16]);
            3'd6: seg_next = seg_digit({1'b0, prog});
            3'd7: begin
                case (modulo)
                    2'b10:   seg_next = SEG_F;
                    2'b01:   seg_next = SEG_T;
                    default: seg_next = SEG_DASH;
                endcase
            end
            default: seg_next = SEG_BLANK;
        endcase
    end

    // an and dec_ddp share one edge so a digit never shows its neighbour's segments.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= 8'hFF;
            dec_ddp  <= 8'hFF;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an      <= ~(8'b1 << idx);
            dec_ddp <= seg_next;
        end
    end

endmodule
